// File: rtl/conv1d_stream_unit.sv
// conv1d_stream_unit: streaming 1-D convolution.
// A KLEN-deep sample window feeds a one-tap-per-cycle signed MAC.
// Samples arrive over a valid/ready stream, and results leave over a second valid/ready stream.
// Frames restart on in_last, and the runtime stride spaces the outputs.
// Optional feature macro: CONV_BIAS_EN. It adds a signed bias port, and the bias becomes the accumulator start value.
module conv1d_stream_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned KLEN     = 4,
    parameter int unsigned STRIDE_W = 4,
`ifdef CONV_BIAS_EN
    localparam int unsigned RES_W   = 2 * DATA_W + $clog2(KLEN) + 1
`else
    localparam int unsigned RES_W   = 2 * DATA_W + $clog2(KLEN)
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [KLEN*DATA_W-1:0]   kernel,
    input  logic [STRIDE_W-1:0]      stride,
`ifdef CONV_BIAS_EN
    input  logic [DATA_W-1:0]        bias,
`endif
    output logic [RES_W-1:0]         result,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned IDX_W  = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam int unsigned FILL_W = $clog2(KLEN + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t                  state;
    state_t                  state_next;

    logic [DATA_W-1:0]       win    [KLEN];
    logic [DATA_W-1:0]       op_win [KLEN];
    logic [DATA_W-1:0]       op_k   [KLEN];
    logic                    op_last;
    logic [FILL_W-1:0]       fill;
    logic [STRIDE_W-1:0]     phase;
    logic [IDX_W-1:0]        idx;
    logic signed [RES_W-1:0] acc;

    logic [STRIDE_W-1:0]     eff_stride_c;
    logic                    full_post_c;
    logic                    trig_pending_c;
    logic                    accept_c;
    logic                    trigger_c;
    logic                    mac_en_c;
    logic                    last_mac_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [RES_W-1:0] acc_sum_c;
    logic signed [RES_W-1:0] acc_init_c;

    // Trigger decode: the window is full after this shift and the stride phase is at zero.
    assign eff_stride_c   = (stride == '0) ? STRIDE_W'(1) : stride;
    assign full_post_c    = (fill >= FILL_W'(KLEN - 1));
    assign trig_pending_c = full_post_c && (phase == '0);
    assign accept_c       = in_valid && in_ready;
    assign trigger_c      = accept_c && trig_pending_c;

    // MAC datapath: the current tap product, sign-extended into the accumulator.
    assign prod_c    = PROD_W'($signed(op_win[idx])) * PROD_W'($signed(op_k[idx]));
    assign acc_sum_c = acc + RES_W'(prod_c);
`ifdef CONV_BIAS_EN
    assign acc_init_c = RES_W'($signed(bias));
`else
    assign acc_init_c = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (trigger_c) state_next = CALC;
            CALC:    if (idx == IDX_W'(KLEN - 1)) state_next = HOLD;
            HOLD:    if (out_ready) state_next = trigger_c ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs: only triggering samples are held off while a result is in flight.
    always_comb begin
        in_ready   = 1'b0;
        mac_en_c   = 1'b0;
        last_mac_c = 1'b0;
        in_ready   = (state == IDLE) || ((state == HOLD) && out_ready) || !trig_pending_c;
        mac_en_c   = (state == CALC);
        last_mac_c = (state == CALC) && (idx == IDX_W'(KLEN - 1));
    end

    // Live sample window, fill count and stride phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KLEN; i++) win[i] <= '0;
            fill  <= '0;
            phase <= '0;
        end else if (accept_c) begin
            win[0] <= in_data;
            for (int i = 1; i < KLEN; i++) win[i] <= win[i-1];
            if (in_last) begin
                fill  <= '0;
                phase <= '0;
            end else begin
                fill <= full_post_c ? FILL_W'(KLEN) : fill + FILL_W'(1);
                if (full_post_c)
                    phase <= (phase >= eff_stride_c - STRIDE_W'(1)) ? '0 : phase + STRIDE_W'(1);
            end
        end
    end

    // Operand snapshot, sequential MAC and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KLEN; i++) begin
                op_win[i] <= '0;
                op_k[i]   <= '0;
            end
            op_last   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            result    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == HOLD);
            if (trigger_c) begin
                op_win[0] <= in_data;
                for (int i = 1; i < KLEN; i++) op_win[i] <= win[i-1];
                for (int i = 0; i < KLEN; i++) op_k[i] <= kernel[i*DATA_W +: DATA_W];
                op_last <= in_last;
                acc     <= acc_init_c;
                idx     <= '0;
            end else if (mac_en_c) begin
                acc <= acc_sum_c;
                idx <= idx + IDX_W'(1);
                if (last_mac_c) begin
                    result   <= acc_sum_c;
                    out_last <= op_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream_unit.sv
// Bench for conv1d_stream_unit.
// A frame-level model predicts every result from the frame history, the kernel and the stride.
// A negedge monitor compares the DUT outputs with the model on every cycle.
// Directed cases pin literal results, and a randomized phase follows them.
module tb_conv1d_stream_unit;

    localparam int DATA_W   = 16;
    localparam int KLEN     = 4;
    localparam int STRIDE_W = 4;
    localparam int RES_W    = 2 * DATA_W + $clog2(KLEN)
`ifdef CONV_BIAS_EN
                              + 1
`endif
                              ;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      in_data;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [KLEN*DATA_W-1:0] kernel;
    logic [STRIDE_W-1:0]    stride;
    logic [RES_W-1:0]       result;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
`ifdef CONV_BIAS_EN
    logic [DATA_W-1:0]      bias = '0;
`endif

    conv1d_stream_unit #(.DATA_W(DATA_W), .KLEN(KLEN), .STRIDE_W(STRIDE_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .kernel(kernel), .stride(stride),
`ifdef CONV_BIAS_EN
        .bias(bias),
`endif
        .result(result), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        bit     last;
        int     tedge;
    } exp_t;

    exp_t   q[$];
    longint hist[$];
    longint got_v[$];
    bit     got_l[$];
    int     cyc = 0;
    int     nvec = 0;
    int     nerr = 0;
    int     rmode = 0;
    bit     stream_done;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff();
        return (stride == '0) ? 1 : int'(stride);
    endfunction

    function automatic longint ktap(input int i);
        logic [DATA_W-1:0] t;
        t = kernel[i*DATA_W +: DATA_W];
        return longint'($signed(t));
    endfunction

    function automatic logic [KLEN*DATA_W-1:0] mk_k(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: model versus DUT on every cycle outside reset.
    always @(negedge clk) begin : mon
        bit     ev;
        bit     er;
        bit     wt;
        int     n;
        longint s;
        if (rst) begin
            q.delete();
            hist.delete();
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].tedge + KLEN);
            n  = hist.size();
            wt = (n + 1 >= KLEN) && (((n + 1 - KLEN) % eff()) == 0);
            er = !wt || (q.size() == 0) || ((q.size() == 1) && ev && out_ready);
            check("out_valid", longint'(out_valid), longint'(ev));
            check("in_ready", longint'(in_ready), longint'(er));
            if (ev && out_valid) begin
                check("result", longint'($signed(result)), q[0].val);
                check("out_last", longint'(out_last), longint'(q[0].last));
                if (out_ready) begin
                    got_v.push_back(q[0].val);
                    got_l.push_back(q[0].last);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                hist.push_back(longint'($signed(in_data)));
                n = hist.size();
                if (n >= KLEN && ((n - KLEN) % eff()) == 0) begin
                    s = 0;
                    for (int i = 0; i < KLEN; i++) s += ktap(i) * hist[n-1-i];
                    q.push_back('{s, in_last, cyc + 1});
                end
                if (in_last) hist.delete();
            end
        end
    end

    // Result-side ready pattern: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input longint d, input bit l);
        bit took;
        int n;
        n = 0;
        in_data  = DATA_W'(d);
        in_last  = l;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            took = in_ready;
            tick();
            n++;
        end while (!took && n < 500);
        if (!took) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: sample %0d not accepted in %0d cycles", d, n);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input int first, input int cnt, input bit last_at_end);
        for (int i = 0; i < cnt; i++) send(longint'(first + i), last_at_end && (i == cnt - 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
        end
        repeat (2) tick();
    endtask

    task automatic check_log(input string nm, input int cnt, input longint e0, input longint e1, input longint e2);
        longint e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        check({nm, "_count"}, longint'(got_v.size()), longint'(cnt));
        for (int i = 0; i < cnt && i < got_v.size(); i++) check(nm, got_v[i], e[i]);
    endtask

    task automatic clear_log();
        got_v.delete();
        got_l.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        stride = 4'd1;
        kernel = mk_k(1, 1, 1, 1);
        repeat (3) tick();
        rst = 1'b0;
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_last", longint'(out_last), 0);
        check("reset_result", longint'($signed(result)), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        tick();

        // All-ones kernel, unit stride: window sums 10 then 14.
        clear_log();
        send_seq(1, 5, 1'b1);
        drain();
        check_log("ones_stride1", 2, 10, 14, 0);

        // Distinct taps: 4*1 + 3*2 + 2*3 + 1*4 = 20.
        clear_log();
        kernel = mk_k(1, 2, 3, 4);
        send_seq(1, 4, 1'b1);
        drain();
        check_log("taps_1234", 1, 20, 0, 0);

        // Most negative operands: 4 * 2^30 must not overflow.
        clear_log();
        kernel = mk_k(-32768, -32768, -32768, -32768);
        for (int i = 0; i < 4; i++) send(-32768, i == 3);
        drain();
        check_log("max_neg", 1, 64'sd4294967296, 0, 0);

        // Stride 2 emits on samples 4, 6 and 8.
        clear_log();
        kernel = mk_k(1, 1, 1, 1);
        stride = 4'd2;
        send_seq(1, 8, 1'b1);
        drain();
        check_log("stride2", 3, 10, 18, 26);

        // Stride 0 must behave like stride 1.
        clear_log();
        stride = 4'd0;
        send_seq(1, 5, 1'b1);
        drain();
        check_log("stride0", 2, 10, 14, 0);

        // Stall the result side: the first result is held, and the next trigger is blocked.
        clear_log();
        stride = 4'd1;
        rmode = 2;
        stream_done = 1'b0;
        fork
            begin
                send_seq(1, 6, 1'b1);
                stream_done = 1'b1;
            end
        join_none
        repeat (20) tick();
        check("stall_in_ready", longint'(in_ready), 0);
        check("stall_out_valid", longint'(out_valid), 1);
        check("stall_result", longint'($signed(result)), 10);
        rmode = 0;
        for (int i = 0; i < 400 && !stream_done; i++) tick();
        check("stall_stream_done", longint'(stream_done), 1);
        drain();
        check_log("stall_release", 3, 10, 14, 18);

        // Frame restart: in_last on sample 5, then a fresh frame of 9s.
        clear_log();
        send_seq(1, 5, 1'b1);
        drain();
        check_log("frame_a", 2, 10, 14, 0);
        if (got_l.size() == 2) begin
            check("frame_a_last0", longint'(got_l[0]), 0);
            check("frame_a_last1", longint'(got_l[1]), 1);
        end
        clear_log();
        for (int i = 0; i < 3; i++) send(9, 1'b0);
        repeat (6) tick();
        check("frame_b_quiet", longint'(got_v.size()), 0);
        send(9, 1'b1);
        drain();
        check_log("frame_b", 1, 36, 0, 0);

        // Reset while the MAC is busy discards the result and restarts the frame.
        clear_log();
        send_seq(1, 4, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_out_valid", longint'(out_valid), 0);
        send_seq(5, 3, 1'b0);
        repeat (6) tick();
        check("rst_mid_quiet", longint'(got_v.size()), 0);
        send(8, 1'b1);
        drain();
        check_log("rst_mid_first", 1, 26, 0, 0);

        // Randomized frames, strides, kernels, gaps and result back-pressure.
        for (int f = 0; f < 40; f++) begin
            int len;
            stride = STRIDE_W'($urandom_range(0, 3));
            kernel = mk_k(int'($urandom()), int'($urandom()), int'($urandom()), int'($urandom()));
            rmode  = int'($urandom_range(0, 1));
            len    = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                send(longint'($signed(16'($urandom()))), i == len - 1);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        rmode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/conv1d_stream_unit.md
Name: conv1d_stream_unit

Overview:
Parametrised streaming 1-D convolution unit for the convolution datapath. It is the successor to the fixed shift-plus-operator unit.
- Input stage: KLEN-deep sample window with frame restart and a runtime stride.
- Compute stage: sequential one-tap-per-cycle signed MAC.
- Both the sample input and the result output use valid/ready handshakes.

Parameters:
DATA_W, 16, signed sample/kernel coefficient width
KLEN, 4, kernel taps / window depth (>=2)
STRIDE_W, 4, width of runtime stride input
RES_W, 2*DATA_W+$clog2(KLEN), result width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  DATA_W  signed sample
in_last  in  1  marks final sample of a frame
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid&&in_ready
kernel  in  KLEN*DATA_W  tap i = kernel[i*DATA_W +: DATA_W], signed
stride  in  STRIDE_W  output spacing in samples; 0 treated as 1
result  out  RES_W  signed sum of products
out_last  out  1  result's window ended with an in_last sample
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&&out_ready

Behaviour:
- Reset: window regs, fill count, phase, acc, result=0; out_valid=0; out_last=0; state IDLE. Reset mid-CALC/HOLD discards the result; out_valid=0 after the reset edge.
- Window: on accept, win[0]<=in_data, win[i]<=win[i-1]; fill count saturates at KLEN.
- Emit rule: an accepted sample triggers when post-shift fill==KLEN and phase==0.
  - Phase advances on each accept while post-shift fill==KLEN.
  - Phase wraps to 0 when phase>=eff_stride-1 (eff_stride = stride==0 ? 1 : stride).
  - Result: first output on the KLEN-th sample of a frame, then every eff_stride samples.
- in_last accept: after the shift/trigger decision, fill count and phase reset to 0, so the next sample starts a new frame.
- Snapshot: a triggering accept copies the post-shift window, kernel and in_last into operand regs. The live window keeps shifting independently.
- FSM IDLE/CALC/HOLD:
  - IDLE: triggering accept -> CALC, acc<=0, idx<=0.
  - CALC: each cycle acc += op[idx]*k[idx] (signed, full RES_W, no overflow possible); idx++; after KLEN MACs -> HOLD, result<=final sum.
  - HOLD: out_valid=1, result/out_last stable. With out_ready: -> IDLE, or -> CALC directly if a triggering accept happens the same edge.
- Latency: out_valid rises exactly KLEN cycles after the triggering accept edge.
- in_ready is high when any of these hold:
  - state==IDLE;
  - state==HOLD && out_ready;
  - the next accept would not trigger.
- Non-triggering samples therefore flow in freely during CALC/HOLD.
- in_ready depends combinationally on out_ready only in HOLD; no combinational path from in_valid to in_ready.
- Kernel/stride changes take effect at the next snapshot or phase comparison; an in-flight result is unaffected.

Optional Feature:
CONV_BIAS_EN:
- Defined:
  - adds port bias in DATA_W (signed);
  - bias is sampled at snapshot;
  - acc initialises to sign-extended bias instead of 0;
  - RES_W grows by 1 bit.
- Undefined: no bias port; acc starts at 0; RES_W as stated.

Test Plan:
- KLEN=4, kernel all 1, stride=1, samples 1,2,3,4,5 -> results 10 then 14; first out_valid 4 cycles after accepting sample 4.
- kernel k0..k3=1,2,3,4, samples 1,2,3,4 (win[0]=4) -> result 20. Repeat with all samples -32768 and all taps -32768 -> result 4*2^30 = 4294967296, no overflow.
- Stride=2, kernel all 1, samples 1..8 -> results 10,18,26 at samples 4,6,8; stride=0 behaves as stride=1.
- out_ready held low 20 cycles during stride=1 stream:
  - in_ready drops only when the next sample would trigger;
  - result 10 held stable;
  - on release, outputs 10,14,18 in order with none lost.
- Samples 1..5, in_last on 5 -> results 10,14 (out_last=1 on 14). Then samples 9,9,9 produce nothing; the 4th new sample 9 -> 36.
- rst pulsed during CALC -> out_valid 0 next cycle; after release, 3 samples give no output and the 4th gives its first result.
